// File: rtl/servisia_mem_bridge.sv
// Bridges 32-bit Wishbone-classic accesses onto an 8-bit byte-wide memory port.
// Reads always fetch all four bytes; writes visit only the enabled byte lanes.
module servisia_mem_bridge #(
    parameter int unsigned MEM_AW = 21
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic              wb_we_i,
    input  logic [31:0]       wb_adr_i,
    input  logic [3:0]        wb_sel_i,
    input  logic [31:0]       wb_dat_i,
    output logic [31:0]       wb_dat_o,
    output logic              wb_ack_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic [MEM_AW-1:0] mem_addr_o,
    output logic [7:0]        mem_wdata_o,
    input  logic [7:0]        mem_rdata_i
);

    typedef enum logic [2:0] {StIdle, StRd, StRdDrain, StWr, StAck} state_e;

    state_e            state_q;
    logic [MEM_AW-3:0] word_adr_q;
    logic [3:0]        sel_q;
    logic [31:0]       dat_q;
    logic [1:0]        k_q;
    logic [23:0]       rd_buf_q;

    logic       first_vld, next_vld;
    logic [1:0] first_idx, next_idx;
    logic       unused_adr;

    assign unused_adr = ^{wb_adr_i[31:MEM_AW], wb_adr_i[1:0]};

    // Returns {found, index} of the lowest set bit.
    function automatic logic [2:0] lowest_set(input logic [3:0] m);
        logic [2:0] r;
        r = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) r = {1'b1, i[1:0]};
        end
        return r;
    endfunction

    always_comb begin
        {first_vld, first_idx} = lowest_set(wb_sel_i);
        {next_vld, next_idx}   = lowest_set(sel_q & (4'b1110 << k_q));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            word_adr_q  <= '0;
            sel_q       <= '0;
            dat_q       <= '0;
            k_q         <= '0;
            rd_buf_q    <= '0;
            wb_ack_o    <= 1'b0;
            wb_dat_o    <= '0;
            mem_read_o  <= 1'b0;
            mem_write_o <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (wb_cyc_i && wb_stb_i) begin
                        word_adr_q <= wb_adr_i[MEM_AW-1:2];
                        sel_q      <= wb_sel_i;
                        dat_q      <= wb_dat_i;
                        if (!wb_we_i) begin
                            state_q    <= StRd;
                            k_q        <= 2'd0;
                            mem_read_o <= 1'b1;
                            mem_addr_o <= {wb_adr_i[MEM_AW-1:2], 2'd0};
                        end else if (first_vld) begin
                            state_q     <= StWr;
                            k_q         <= first_idx;
                            mem_write_o <= 1'b1;
                            mem_addr_o  <= {wb_adr_i[MEM_AW-1:2], first_idx};
                            mem_wdata_o <= wb_dat_i[{first_idx, 3'b000} +: 8];
                        end else begin
                            // Empty byte-enable write: acknowledge without touching memory.
                            state_q  <= StAck;
                            wb_ack_o <= 1'b1;
                            wb_dat_o <= '0;
                        end
                    end
                end
                StRd: begin
                    if (!wb_cyc_i) begin
                        state_q    <= StIdle;
                        mem_read_o <= 1'b0;
                    end else begin
                        // Data for the previous address arrives one cycle late.
                        case (k_q)
                            2'd1:    rd_buf_q[7:0]   <= mem_rdata_i;
                            2'd2:    rd_buf_q[15:8]  <= mem_rdata_i;
                            2'd3:    rd_buf_q[23:16] <= mem_rdata_i;
                            default: ;
                        endcase
                        if (k_q == 2'd3) begin
                            state_q    <= StRdDrain;
                            mem_read_o <= 1'b0;
                        end else begin
                            k_q        <= k_q + 2'd1;
                            mem_addr_o <= {word_adr_q, k_q + 2'd1};
                        end
                    end
                end
                StRdDrain: begin
                    if (!wb_cyc_i) begin
                        state_q <= StIdle;
                    end else begin
                        state_q  <= StAck;
                        wb_ack_o <= 1'b1;
                        wb_dat_o <= {mem_rdata_i, rd_buf_q};
                    end
                end
                StWr: begin
                    if (!wb_cyc_i) begin
                        state_q     <= StIdle;
                        mem_write_o <= 1'b0;
                        mem_wdata_o <= '0;
                    end else if (next_vld) begin
                        k_q         <= next_idx;
                        mem_addr_o  <= {word_adr_q, next_idx};
                        mem_wdata_o <= dat_q[{next_idx, 3'b000} +: 8];
                    end else begin
                        state_q     <= StAck;
                        mem_write_o <= 1'b0;
                        mem_wdata_o <= '0;
                        wb_ack_o    <= 1'b1;
                        wb_dat_o    <= '0;
                    end
                end
                StAck: begin
                    state_q  <= StIdle;
                    wb_ack_o <= 1'b0;
                    wb_dat_o <= '0;
                end
                default: begin
                    state_q     <= StIdle;
                    wb_ack_o    <= 1'b0;
                    wb_dat_o    <= '0;
                    mem_read_o  <= 1'b0;
                    mem_write_o <= 1'b0;
                    mem_wdata_o <= '0;
                end
            endcase
        end
    end

endmodule
